wb_scoreboard: RTL and testbench
================================

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_regw  in  1  the presented instruction writes a register.
- issue_rd  in  5  destination register of the presented instruction.
- rs1_used, rs2_used  in  1 each  source operand is read.
- rs1, rs2  in  5 each  source register indices.
- wb_regw  in  1  writeback stage commits a register write this cycle (writeback regw).
- wb_rd  in  5  register written by writeback.
- flush  in  1  pipeline squash request.
- stall  out  1  combinational; decode SHALL hold its instruction.
- issue_ack  out  1  combinational; the presented instruction is accepted.
- busy_any  out  1  registered; at least one write outstanding.
- err  out  1  registered, sticky; protocol violation seen.

Function
REQ-002 The block SHALL hold a 2-bit pending count per register 1..31; register 0 SHALL never be counted, never stall, and never flag err.
REQ-003 The block SHALL hold a 7-bit total of all pending counts; busy_any SHALL be registered (total != 0) after each update.
REQ-004 Source hazard: rsN is hazardous when rsN_used=1, rsN!=0 and cnt[rsN]!=0, except when cnt[rsN]=1 and wb_regw=1 with wb_rd=rsN this cycle (write-through register file supplies the value).
REQ-005 Destination saturation: a hazard exists when issue_regw=1, issue_rd!=0 and cnt[issue_rd]=3, unless writeback retires issue_rd this cycle.
REQ-006 stall SHALL = issue_valid AND (any hazard OR flush OR state=DRAIN); issue_ack SHALL = issue_valid AND NOT stall.
REQ-007 On issue_ack with issue_regw=1 and issue_rd!=0, cnt[issue_rd] SHALL increment at the next edge; total SHALL increment.
REQ-008 On wb_regw=1 with wb_rd!=0 and cnt[wb_rd]!=0, cnt[wb_rd] SHALL decrement at the next edge; total SHALL decrement.
REQ-009 Increment and decrement of the same register in one cycle SHALL leave that count unchanged; on different registers both SHALL apply; total SHALL change by the net amount.
REQ-010 A writeback to a register with count 0 SHALL leave counts unchanged and SHALL set err at the next edge; err SHALL clear only on rst.
REQ-011 Counts SHALL never wrap; REQ-005 guarantees no increment at 3.
REQ-012 State machine, two states: RUN, DRAIN.
- RUN: flush=1 -> DRAIN; otherwise stay.
- DRAIN: all issue stalled; writebacks still decrement; when total=0 and flush=0 -> RUN at the next edge; otherwise stay.
REQ-013 Flush in RUN with total=0 SHALL spend exactly one cycle in DRAIN, then return to RUN.
REQ-014 Latency: a writeback in cycle N SHALL release a dependent stall in cycle N itself (REQ-004 bypass) when it clears the last pending write; a write issued in cycle N SHALL be visible to hazard checks in cycle N+1.

Reset
REQ-015 During rst, at the next edge: all counts 0, total 0, state RUN, busy_any 0, err 0.
REQ-016 rst SHALL take priority over issue, writeback and flush in the same cycle; stall and issue_ack SHALL follow REQ-006 using the post-reset state from the first cycle after rst deasserts.

Verification
REQ-017 Basic RAW: issue rd=5 regw; next cycle issue rs1=5 -> stall=1; writeback wb_rd=5 in a later cycle -> stall=0 in that same cycle, issue_ack=1.
REQ-018 Saturation: three accepted issues to rd=7 with no writeback -> cnt[7]=3; a fourth issue to rd=7 -> stall=1; with wb_rd=7 in the same cycle -> issue_ack=1, cnt[7] stays 3.
REQ-019 Simultaneous: cnt[3]=1; issue rd=3 and wb_rd=3 in one cycle -> cnt[3]=1, total unchanged, busy_any=1.
REQ-020 Flush drain: total=2 (rd=4, rd=9); flush one cycle -> DRAIN, stall=1 for any issue; wb 4 then wb 9 -> RUN one cycle after total reaches 0; busy_any=0.
REQ-021 Error and reg 0: wb_rd=12 with cnt[12]=0 -> err=1 next cycle, counts unchanged; issue rd=0 and rs1=0 -> no stall, total unchanged.
REQ-022 Reset mid-operation: total=5, state DRAIN, rst one cycle -> total=0, RUN, busy_any=0, err=0; the next issue with rs1=previously busy register -> issue_ack=1.

Source files
------------

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Per-register pending-write scoreboard with RAW/saturation stall
//            and a flush drain state.
// Revision : 1.0
// ============================================================================
module wb_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_regw,
    input  logic [4:0] issue_rd,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       wb_regw,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    output logic       stall,
    output logic       issue_ack,
    output logic       busy_any,
    output logic       err
);

    localparam logic [1:0] CNT_MAX = 2'd3;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q [0:31];
    logic [1:0] cnt_d [0:31];
    logic [6:0] total_q, total_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic       haz_rs1, haz_rs2, haz_rd;
    logic       wb_live, inc, dec, wb_bad, same_reg;

    assign wb_live = wb_regw && (wb_rd != 5'd0);

    // A source whose last pending write retires this cycle is bypassed by the
    // write-through register file, so it is not a hazard.
    always_comb begin
        haz_rs1 = rs1_used && (rs1 != 5'd0) && (cnt_q[rs1] != 2'd0) &&
                  !((cnt_q[rs1] == 2'd1) && wb_regw && (wb_rd == rs1));
        haz_rs2 = rs2_used && (rs2 != 5'd0) && (cnt_q[rs2] != 2'd0) &&
                  !((cnt_q[rs2] == 2'd1) && wb_regw && (wb_rd == rs2));
        haz_rd  = issue_regw && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CNT_MAX) &&
                  !(wb_regw && (wb_rd == issue_rd));
    end

    assign stall     = issue_valid && (haz_rs1 || haz_rs2 || haz_rd || flush ||
                                       (state_q == DRAIN));
    assign issue_ack = issue_valid && !stall;

    assign inc      = issue_ack && issue_regw && (issue_rd != 5'd0);
    assign dec      = wb_live && (cnt_q[wb_rd] != 2'd0);
    assign wb_bad   = wb_live && (cnt_q[wb_rd] == 2'd0);
    assign same_reg = (issue_rd == wb_rd);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (inc && !(dec && same_reg)) begin
            cnt_d[issue_rd] = cnt_q[issue_rd] + 2'd1;
        end
        if (dec && !(inc && same_reg)) begin
            cnt_d[wb_rd] = cnt_q[wb_rd] - 2'd1;
        end
        cnt_d[0] = 2'd0;

        total_d = total_q;
        if (inc && !dec) begin
            total_d = total_q + 7'd1;
        end else if (dec && !inc) begin
            total_d = total_q - 7'd1;
        end

        busy_d = (total_d != 7'd0);
        err_d  = err_q || wb_bad;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if ((total_q == 7'd0) && !flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= 2'd0;
            end
            total_q <= 7'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= RUN;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            total_q <= total_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign busy_any = busy_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_scoreboard
// Purpose  : Directed self-checking bench for wb_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_wb_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_regw, rs1_used, rs2_used, wb_regw, flush;
    logic [4:0] issue_rd, rs1, rs2, wb_rd;
    logic       stall, issue_ack, busy_any, err;

    int n_tests = 0;
    int n_fail  = 0;

    wb_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_regw (issue_regw),
        .issue_rd   (issue_rd),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .rs1        (rs1),
        .rs2        (rs2),
        .wb_regw    (wb_regw),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .stall      (stall),
        .issue_ack  (issue_ack),
        .busy_any   (busy_any),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_regw = 1'b0; issue_rd = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        wb_regw = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    endtask

    // Commit current inputs at the next rising edge; return just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic issue_w(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_regw = 1'b1; issue_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        wb_regw = 1'b1; wb_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        settle();
        chk("rst_busy",  busy_any, 0);
        chk("rst_err",   err, 0);
        chk("rst_total", dut.total_q, 0);
        chk("rst_state", dut.state_q, 0);

        // Basic RAW
        issue_w(5'd5); settle();
        chk("raw_issue_ack", issue_ack, 1);
        step();
        idle(); issue_valid = 1'b1; rs1_used = 1'b1; rs1 = 5'd5; settle();
        chk("raw_busy", busy_any, 1);
        chk("raw_stall", stall, 1);
        chk("raw_noack", issue_ack, 0);
        step(); settle();
        chk("raw_stall_hold", stall, 1);
        wb_regw = 1'b1; wb_rd = 5'd5; #1;
        chk("raw_bypass_stall", stall, 0);
        chk("raw_bypass_ack", issue_ack, 1);
        step(); idle(); settle();
        chk("raw_total0", dut.total_q, 0);
        chk("raw_busy0", busy_any, 0);

        // Saturation
        for (int k = 0; k < 3; k++) begin
            issue_w(5'd7); settle();
            chk("sat_ack", issue_ack, 1);
            step();
        end
        idle(); settle();
        chk("sat_cnt3", dut.cnt_q[7], 3);
        issue_w(5'd7); settle();
        chk("sat_stall", stall, 1);
        wb_regw = 1'b1; wb_rd = 5'd7; #1;
        chk("sat_wb_ack", issue_ack, 1);
        step(); idle(); settle();
        chk("sat_cnt_keep", dut.cnt_q[7], 3);
        chk("sat_total", dut.total_q, 3);
        for (int k = 0; k < 3; k++) begin
            wb(5'd7); step();
        end
        idle(); settle();
        chk("sat_drained", dut.total_q, 0);

        // Simultaneous issue and writeback on same register
        issue_w(5'd3); step();
        issue_w(5'd3); wb_regw = 1'b1; wb_rd = 5'd3; settle();
        chk("sim_ack", issue_ack, 1);
        step(); idle(); settle();
        chk("sim_cnt", dut.cnt_q[3], 1);
        chk("sim_total", dut.total_q, 1);
        chk("sim_busy", busy_any, 1);
        // Different registers in one cycle
        issue_w(5'd11); wb_regw = 1'b1; wb_rd = 5'd3; step(); idle(); settle();
        chk("diff_cnt3", dut.cnt_q[3], 0);
        chk("diff_cnt11", dut.cnt_q[11], 1);
        chk("diff_total", dut.total_q, 1);
        wb(5'd11); step(); idle(); settle();
        chk("diff_total0", dut.total_q, 0);

        // Flush drain
        issue_w(5'd4); step();
        issue_w(5'd9); step();
        idle(); issue_valid = 1'b1; flush = 1'b1; settle();
        chk("fl_stall_flush", stall, 1);
        step(); idle(); settle();
        chk("fl_state_drain", dut.state_q, 1);
        chk("fl_total2", dut.total_q, 2);
        issue_valid = 1'b1; #1;
        chk("fl_stall_drain", stall, 1);
        wb(5'd4); step();
        wb(5'd9); step(); idle(); settle();
        chk("fl_total0", dut.total_q, 0);
        chk("fl_still_drain", dut.state_q, 1);
        chk("fl_busy0", busy_any, 0);
        step(); settle();
        chk("fl_back_run", dut.state_q, 0);
        issue_valid = 1'b1; #1;
        chk("fl_ack_run", issue_ack, 1);

        // Flush with nothing outstanding: exactly one DRAIN cycle
        idle(); flush = 1'b1; step(); idle(); settle();
        chk("fl0_drain", dut.state_q, 1);
        step(); settle();
        chk("fl0_run", dut.state_q, 0);

        // Register 0 and error
        wb(5'd0); step(); idle(); settle();
        chk("r0_wb_noerr", err, 0);
        wb(5'd12); step(); idle(); settle();
        chk("err_set", err, 1);
        chk("err_total", dut.total_q, 0);
        chk("err_cnt12", dut.cnt_q[12], 0);
        step(); settle();
        chk("err_sticky", err, 1);
        issue_w(5'd0); rs1_used = 1'b1; rs1 = 5'd0; settle();
        chk("r0_nostall", stall, 0);
        step(); idle(); settle();
        chk("r0_total", dut.total_q, 0);

        // Reset mid-operation
        issue_w(5'd1);  step();
        issue_w(5'd2);  step();
        issue_w(5'd6);  step();
        issue_w(5'd8);  step();
        issue_w(5'd10); step();
        idle(); flush = 1'b1; step(); idle(); settle();
        chk("mr_total5", dut.total_q, 5);
        chk("mr_drain", dut.state_q, 1);
        issue_w(5'd13); wb_regw = 1'b1; wb_rd = 5'd20; flush = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; idle(); settle();
        chk("mr_total0", dut.total_q, 0);
        chk("mr_run", dut.state_q, 0);
        chk("mr_busy0", busy_any, 0);
        chk("mr_err0", err, 0);
        issue_valid = 1'b1; rs1_used = 1'b1; rs1 = 5'd1; #1;
        chk("mr_ack", issue_ack, 1);
        step(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
